// File: rtl/pio_pwm_driver_pkg.sv
// Shared types and constants for the PIO-driven PWM block.
package pio_pwm_pkg;

   // Width of the PIO level and of the PWM step counter.
   localparam int DUTY_W    = 4;
   localparam int PWM_STEPS = 16;
   localparam int STEP_W    = $clog2(PWM_STEPS);

   typedef logic [DUTY_W-1:0] duty_t;
   typedef logic [STEP_W-1:0] step_t;

   // Index of the final step in a period; a tick on this step ends the period.
   localparam step_t LAST_STEP = step_t'(PWM_STEPS - 1);

   // Output level for one step: on while the step index is below the duty.
   // A duty of 0 is always off and the top duty value leaves one step off,
   // so a 100% level is deliberately unreachable.
   function automatic logic pwm_level(input step_t s, input duty_t d, input logic inv);
      return (s < d) ^ inv;
   endfunction

endpackage

// File: rtl/pio_pwm_driver_if.sv
// Signal bundle between the PIO output register and the PWM driver.
interface pio_pwm_driver_if;
   import pio_pwm_pkg::*;

   // There is no valid/ready handshake here: duty_in is a plain level that
   // the driver samples on every clock, and every output is a registered
   // level or one-cycle strobe that the consumer may sample on any clock.
   duty_t duty_in;
   logic  pwm_out;
   duty_t duty_active;
   logic  period_start;
   logic  duty_changed;

   // PIO / processor side: drives the level, observes the waveform and strobes.
   modport master (
      output duty_in,
      input  pwm_out,
      input  duty_active,
      input  period_start,
      input  duty_changed
   );

   // PWM driver side.
   modport slave (
      input  duty_in,
      output pwm_out,
      output duty_active,
      output period_start,
      output duty_changed
   );

endinterface

// File: rtl/pio_pwm_driver_prescaler.sv
// Clock prescaler: produces one tick every PRESCALE cycles.
module pwm_prescaler #(
   parameter int PRESCALE = 64
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   // A one-cycle prescale still needs a one-bit counter that simply stays at 0.
   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("pwm_prescaler: PRESCALE must be at least 1");
   end

   logic [CNT_W-1:0] pre_cnt;

   // Tick on the last count so the first tick lands PRESCALE cycles after reset.
   assign tick = (pre_cnt == CNT_LAST);

   // Count 0..PRESCALE-1 and wrap on the tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pio_pwm_driver.sv
// Converts the 4-bit PIO level into a 16-step PWM waveform. The duty is
// latched into a shadow register only at period boundaries, so software
// writes never produce runt pulses.
module pio_pwm_driver
   import pio_pwm_pkg::*;
#(
   parameter int PRESCALE = 64,
   parameter int INVERT   = 0
) (
   input  logic              clk,
   input  logic              reset,
   pio_pwm_driver_if.slave   pio
);

   localparam logic INV = (INVERT != 0);

   logic  tick;
   logic  wrap;
   step_t step;
   duty_t duty_shadow;
   duty_t duty_prev;
   logic  pwm_q;
   logic  pwm_next;
   logic  period_start_q;
   logic  duty_changed_q;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Period boundary detection and the compare feeding the output flop.
   always_comb begin
      wrap     = tick && (step == LAST_STEP);
      pwm_next = pwm_level(step, duty_shadow, INV);
   end

   // Step counter advances once per prescaler tick and wraps 15 -> 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step <= '0;
      end else if (tick) begin
         step <= step + step_t'(1);
      end
   end

   // Shadow duty: take the level present on the wrap cycle, ignore the rest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_shadow <= '0;
      end else if (wrap) begin
         duty_shadow <= pio.duty_in;
      end
   end

   // Registered waveform and period-start strobe (first cycle of step 0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_q          <= INV;
         period_start_q <= 1'b0;
      end else begin
         pwm_q          <= pwm_next;
         period_start_q <= wrap;
      end
   end

   // Change strobe, independent of the period logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_prev      <= '0;
         duty_changed_q <= 1'b0;
      end else begin
         duty_prev      <= pio.duty_in;
         duty_changed_q <= (pio.duty_in != duty_prev);
      end
   end

   assign pio.pwm_out      = pwm_q;
   assign pio.duty_active  = duty_shadow;
   assign pio.period_start = period_start_q;
   assign pio.duty_changed = duty_changed_q;

endmodule

// File: tb/tb_pio_pwm_driver.sv
// Bench for pio_pwm_driver: three instances (normal, inverted, inverted with
// a one-cycle prescale) checked every cycle against a closed-form reference,
// plus per-period tables and directed corner sequences.
module tb_pio_pwm_driver;
   import pio_pwm_pkg::*;

   localparam int MAXC = 4096;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pio_pwm_driver_if if_a ();
   pio_pwm_driver_if if_b ();
   pio_pwm_driver_if if_c ();

   pio_pwm_driver #(.PRESCALE(4), .INVERT(0)) dut_a (.clk(clk), .reset(reset), .pio(if_a.slave));
   pio_pwm_driver #(.PRESCALE(4), .INVERT(1)) dut_b (.clk(clk), .reset(reset), .pio(if_b.slave));
   pio_pwm_driver #(.PRESCALE(1), .INVERT(1)) dut_c (.clk(clk), .reset(reset), .pio(if_c.slave));

   // ---------------- bookkeeping ----------------
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n;                 // clock edges since reset release
   duty_t dh [3][MAXC];      // duty_in held during state index m (before edge m+1)
   int    hi [3];
   int    ps_cnt;
   int    dc_cnt;

   typedef struct {
      duty_t duty;
      int    hi_a;
      int    hi_b;
      int    hi_c;
      duty_t act;
   } vec_t;
   vec_t tbl [8];

   function automatic int pre_of(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   function automatic logic inv_of(input int d);
      return (d != 0);
   endfunction

   function automatic logic [6:0] dut_out(input int d);
      case (d)
         0:       return {if_a.pwm_out, if_a.duty_active, if_a.period_start, if_a.duty_changed};
         1:       return {if_b.pwm_out, if_b.duty_active, if_b.period_start, if_b.duty_changed};
         default: return {if_c.pwm_out, if_c.duty_active, if_c.period_start, if_c.duty_changed};
      endcase
   endfunction

   function automatic duty_t cur_duty(input int d);
      case (d)
         0:       return if_a.duty_in;
         1:       return if_b.duty_in;
         default: return if_c.duty_in;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_duty(input int d, input duty_t v);
      case (d)
         0:       if_a.duty_in = v;
         1:       if_b.duty_in = v;
         default: if_c.duty_in = v;
      endcase
   endtask

   // ---------------- reference model ----------------
   // Everything is derived from the edge count: the period is 16*P cycles,
   // the step is the elapsed count divided by P, and the duty in force during
   // period k is whatever duty_in held on the last cycle of period k-1.
   function automatic int shadow_at(input int d, input int m);
      int len;
      len = 16 * pre_of(d);
      if (m < len) return 0;
      return int'(dh[d][(m / len) * len - 1]);
   endfunction

   function automatic int step_at(input int d, input int m);
      return (m / pre_of(d)) % 16;
   endfunction

   function automatic int prev_at(input int d, input int m);
      return (m == 0) ? 0 : int'(dh[d][m-1]);
   endfunction

   function automatic logic [6:0] model_out(input int d, input int m);
      logic  pwm;
      logic  ps;
      logic  dc;
      duty_t act;
      int    len;
      len = 16 * pre_of(d);
      if (m == 0) pwm = inv_of(d);
      else        pwm = (step_at(d, m-1) < shadow_at(d, m-1)) ^ inv_of(d);
      act = duty_t'(shadow_at(d, m));
      ps  = (m > 0) && (m % len == 0);
      dc  = (m == 0) ? 1'b0 : (int'(dh[d][m-1]) != prev_at(d, m-1));
      return {pwm, act, ps, dc};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at n=%0d: actual=%0h required=%0h", name, n, act, exp);
      end
   endtask

   task automatic check_model();
      logic [6:0] o;
      for (int d = 0; d < 3; d++) begin
         o = dut_out(d);
         check($sformatf("model_dut%0d", d), int'(o), int'(model_out(d, n)));
         hi[d] += int'(o[6]);
         if (d == 0) begin
            ps_cnt += int'(o[1]);
            dc_cnt += int'(o[0]);
         end
      end
   endtask

   // Record inputs for this state, advance one edge, sample on the falling edge.
   task automatic tick_cycle();
      for (int d = 0; d < 3; d++) dh[d][n] = cur_duty(d);
      @(posedge clk);
      n++;
      if (n >= MAXC) begin
         $display("FAIL cycle_budget: actual=%0d required<%0d", n, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic run_cycles(input int k);
      for (int i = 0; i < k; i++) tick_cycle();
   endtask

   task automatic clear_counts();
      for (int d = 0; d < 3; d++) hi[d] = 0;
      ps_cnt = 0;
      dc_cnt = 0;
   endtask

   task automatic run_period(input duty_t v);
      set_duty(0, v);
      clear_counts();
      run_cycles(64);
   endtask

   // Assert reset on a falling edge, check outputs clear at once, then release.
   task automatic do_reset();
      logic [6:0] o;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         o = dut_out(d);
         check($sformatf("reset_out_dut%0d", d), int'(o), int'({inv_of(d), 4'h0, 1'b0, 1'b0}));
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n = 0;
      clear_counts();
      check_model();
   endtask

   // ---------------- test ----------------
   initial begin
      tbl[0] = '{duty: 4'd0,  hi_a: 0,  hi_b: 64, hi_c: 19, act: 4'd0};
      tbl[1] = '{duty: 4'd0,  hi_a: 0,  hi_b: 4,  hi_c: 4,  act: 4'd0};
      tbl[2] = '{duty: 4'd0,  hi_a: 0,  hi_b: 4,  hi_c: 4,  act: 4'd0};
      tbl[3] = '{duty: 4'd8,  hi_a: 0,  hi_b: 4,  hi_c: 4,  act: 4'd8};
      tbl[4] = '{duty: 4'd8,  hi_a: 32, hi_b: 4,  hi_c: 4,  act: 4'd8};
      tbl[5] = '{duty: 4'd0,  hi_a: 32, hi_b: 4,  hi_c: 4,  act: 4'd0};
      tbl[6] = '{duty: 4'd15, hi_a: 0,  hi_b: 4,  hi_c: 4,  act: 4'd15};
      tbl[7] = '{duty: 4'd4,  hi_a: 60, hi_b: 4,  hi_c: 4,  act: 4'd4};

      n = 0;
      set_duty(0, 4'd0);
      set_duty(1, 4'd15);
      set_duty(2, 4'd15);
      @(negedge clk);
      do_reset();

      // Whole periods from the table.
      for (int i = 0; i < 8; i++) begin
         run_period(tbl[i].duty);
         check($sformatf("tbl%0d_high_a", i), hi[0], tbl[i].hi_a);
         check($sformatf("tbl%0d_high_b", i), hi[1], tbl[i].hi_b);
         check($sformatf("tbl%0d_high_c", i), hi[2], tbl[i].hi_c);
         check($sformatf("tbl%0d_period_start", i), ps_cnt, 1);
         check($sformatf("tbl%0d_active", i), int'(if_a.duty_active), int'(tbl[i].act));
      end

      // 4 -> 12 mid-period: current period keeps duty 4, strobe once.
      clear_counts();
      run_cycles(20);
      set_duty(0, 4'd12);
      tick_cycle();
      check("chg_strobe_next_cycle", int'(if_a.duty_changed), 1);
      run_cycles(43);
      check("chg_high_cur", hi[0], 16);
      check("chg_strobe_count", dc_cnt, 1);
      run_period(4'd12);
      check("chg_high_next", hi[0], 48);

      // 3 -> 9 -> 5 in one period: only the last value is loaded.
      clear_counts();
      run_cycles(5);
      set_duty(0, 4'd3);
      run_cycles(15);
      set_duty(0, 4'd9);
      run_cycles(20);
      set_duty(0, 4'd5);
      run_cycles(24);
      check("multi_high_cur", hi[0], 48);
      check("multi_strobe_count", dc_cnt, 3);
      check("multi_active", int'(if_a.duty_active), 5);
      run_period(4'd5);
      check("multi_high_next", hi[0], 20);

      // Change presented exactly on the wrap cycle: one-cycle latency.
      run_cycles(63);
      check("wrap_active_before", int'(if_a.duty_active), 5);
      set_duty(0, 4'd7);
      tick_cycle();
      check("wrap_active_after", int'(if_a.duty_active), 7);
      run_period(4'd7);
      check("wrap_high_next", hi[0], 28);

      // Randomised levels on all three instances, reference-checked per cycle.
      for (int p = 0; p < 12; p++) begin
         for (int c = 0; c < 64; c++) begin
            for (int d = 0; d < 3; d++) begin
               if ($urandom_range(0, 15) == 0) set_duty(d, duty_t'($urandom_range(0, 15)));
            end
            tick_cycle();
         end
      end

      // Reset mid-period with duty 10 in effect.
      run_period(4'd10);
      run_period(4'd10);
      check("rst_pre_active", int'(if_a.duty_active), 10);
      run_cycles(30);
      do_reset();
      run_period(4'd10);
      check("rst_first_high", hi[0], 0);
      check("rst_first_active", int'(if_a.duty_active), 10);
      run_period(4'd10);
      check("rst_second_high", hi[0], 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_pwm_driver.md
# pio_pwm_driver

Downstream consumer of the 4-bit Avalon PIO output register: converts the 4-bit level written by the processor into a glitch-free 16-step PWM waveform, e.g. for LED brightness or buzzer drive. The duty value is sampled only at PWM period boundaries, so software writes never produce runt pulses. The block also emits a one-cycle change strobe and a period-start strobe for debug or interrupt logic. It sits between the PIO `out_port` and the board pin, in the same clock domain as the PIO.

## Interface
Parameters:
- `PRESCALE`, default 64: clock cycles per PWM step. Legal range is ≥ 1; elaboration fails otherwise.
- `INVERT`, default 0: when 1, the PWM output polarity is inverted (active-low pins).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `duty_in`  in  4  level from the PIO `out_port`.
- `pwm_out`  out  1  registered PWM waveform.
- `duty_active`  out  4  duty value currently in effect (shadow register).
- `period_start`  out  1  one-cycle pulse on the first cycle of each PWM period.
- `duty_changed`  out  1  one-cycle pulse when `duty_in` differs from its previous-cycle value.

## Operation
- **Prescaler:** `pre_cnt` counts 0..PRESCALE-1 and wraps to 0. `tick` is asserted when `pre_cnt == PRESCALE-1`. With PRESCALE = 1, `tick` is asserted every cycle.
- **Step counter:** `step` is 4 bits and increments on `tick`, wrapping 15→0. `wrap` is defined as `tick && step == 15`.
- **Shadow duty:**
  - On `wrap`, `duty_shadow` loads `duty_in` as presented on that same cycle.
  - Changes to `duty_in` at any other time have no effect until the next `wrap`. With several changes in one period, the last value present at `wrap` wins.
- **PWM compare:** `pwm_out <= (step < duty_shadow) ^ INVERT`, compared as an unsigned 4-bit value.
  - duty 0 gives constant off.
  - duty 15 gives high for 15 of 16 steps. A 100% duty is not supported by design.
- **period_start:** registered; it is 1 on the cycle after `wrap`, i.e. the first cycle where `step == 0`.
- **duty_changed:**
  - `duty_prev <= duty_in` every cycle.
  - `duty_changed <= (duty_in != duty_prev)`.
  - This is independent of the period logic.
- **Reset values:**
  - Internal state: `pre_cnt = 0`, `step = 0`, `duty_shadow = 0`, `duty_prev = 0`.
  - Outputs: `pwm_out = INVERT`, `duty_active = 0`, `period_start = 0`, `duty_changed = 0`.
- **Reset mid-period:** all state returns to the reset values immediately (asynchronous). The first period after reset always runs at duty 0.

## Timing
- PWM period is 16 × PRESCALE cycles; each step lasts PRESCALE cycles.
- `pwm_out` lags the `step`/`duty_shadow` compare by 1 cycle. Its edges fall on step boundaries plus 1 cycle.
- Worst-case latency from a `duty_in` change to a new `duty_active` is one full period plus 1 cycle. The best case is 1 cycle (change presented exactly on the `wrap` cycle).
- `duty_active` updates on the clock edge that ends the `wrap` cycle. `pwm_out` reflects the new duty from the first step of the next period.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion is assumed synchronised externally; the first `tick` occurs PRESCALE cycles after release.

## Structure
- Package `pio_pwm_pkg` holds:
  - `DUTY_W = 4`
  - `PWM_STEPS = 16`
  - typedef `duty_t` (logic [DUTY_W-1:0])
- Sub-module `pwm_prescaler`:
  - Parameter: PRESCALE.
  - Ports: `clk`, `reset`, output `tick`.
  - Counter width is `$clog2(PRESCALE)`, with a minimum of 1 bit.
- The top level holds the step counter, shadow register, compare, and strobes.

## Test plan
All scenarios use PRESCALE = 4 (period 64 cycles) unless noted.
- Reset, `duty_in` = 0 → `pwm_out` is 0 for ≥ 3 periods; `period_start` pulses every 64 cycles; `duty_active` = 0.
- `duty_in` = 8 held from reset → first period entirely low. From the second period, `pwm_out` is high for 32 consecutive cycles then low for 32; `duty_active` = 8.
- `duty_in` 4→12 mid-period → the current period keeps 16 high cycles; the next period has 48 high cycles. `duty_changed` pulses exactly once, 1 cycle after the change.
- Change `duty_in` 3→9→5 within one period → only 5 is loaded at `wrap`. `duty_changed` pulses 3 times in total.
- `duty_in` = 15 with INVERT = 1 → `pwm_out` is low for 60 cycles and high for 4 per period. With PRESCALE = 1, the period is 16 cycles and the output is low for 15 cycles.
- Assert `reset` mid-period with duty 10 active → all outputs return to reset values within the same cycle. After release, the duty-0 first period is observed before 10 is reloaded.
